// File: rtl/alu_pkg.sv
// Shared definitions for the ALU: opcodes, flag bit positions, FSM states and
// small flag helpers used by alu_core.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_NOT  = 4'h5;
  localparam logic [3:0] ALU_SHL  = 4'h6;
  localparam logic [3:0] ALU_SHR  = 4'h7;
  localparam logic [3:0] ALU_SAR  = 4'h8;
  localparam logic [3:0] ALU_ADC  = 4'h9;
  localparam logic [3:0] ALU_SBB  = 4'hA;
  localparam logic [3:0] ALU_CMP  = 4'hB;
  localparam logic [3:0] ALU_INC  = 4'hC;
  localparam logic [3:0] ALU_DEC  = 4'hD;
  localparam logic [3:0] ALU_PASS = 4'hE;
  localparam logic [3:0] ALU_MUL  = 4'hF;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_V = 2;
  localparam int FLAG_S = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } alu_state_t;

  // Signed overflow from operand and result sign bits only.
  function automatic logic ovf_add(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic ovf_sub(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic [3:0] pack_flags(input logic c, input logic z, input logic v,
                                            input logic s);
    logic [3:0] f;
    f         = '0;
    f[FLAG_C] = c;
    f[FLAG_Z] = z;
    f[FLAG_V] = v;
    f[FLAG_S] = s;
    return f;
  endfunction

endpackage

// File: rtl/alu_mul_seq.sv
// Shift-add multiplier: load latches operands, each step retires one multiplier bit.
// product_next is the product after the current step, so the caller can capture it on the last edge.
module alu_mul_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 step,
  input  logic [WIDTH-1:0]     mcand,
  input  logic [WIDTH-1:0]     mplier,
  output logic [2*WIDTH-1:0]   product_next
);

  logic [2*WIDTH-1:0] product;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH:0]     hi_sum;

  // Upper half accumulates; the multiplier drains out of the lower half as it shifts right.
  assign hi_sum       = {1'b0, product[2*WIDTH-1:WIDTH]} +
                        {1'b0, (product[0] ? mcand_q : {WIDTH{1'b0}})};
  assign product_next = {hi_sum, product[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (rst) begin
      product <= '0;
      mcand_q <= '0;
    end else if (load) begin
      product <= {{WIDTH{1'b0}}, mplier};
      mcand_q <= mcand;
    end else if (step) begin
      product <= product_next;
    end
  end

endmodule

// File: rtl/alu_core.sv
// Registered 16-bit ALU with C/Z/V/S flags and a busy/done handshake.
// Build option ALU_MUL_EN: opcode F runs the iterative multiplier; otherwise opcode F is a NOP.
//
// state   | meaning
// ST_IDLE | accepting starts; single-cycle ops complete on the accepting edge
// ST_MUL  | multiply in progress, alu_busy=1, starts ignored
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MUL_STEPS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_start,
  input  logic [3:0]       alu_op,
  input  logic             flag_we,
  input  logic [WIDTH-1:0] alu_sr,
  input  logic [WIDTH-1:0] alu_dr,
  output logic [WIDTH-1:0] alu_result,
  output logic             alu_busy,
  output logic             alu_done,
  output logic             flag_c,
  output logic             flag_z,
  output logic             flag_v,
  output logic             flag_s
);

  localparam int MSB = WIDTH - 1;
  localparam logic [WIDTH:0] ONE_X = (WIDTH + 1)'(1);

  if (MUL_STEPS != WIDTH) begin : g_bad_steps
    $error("alu_core: MUL_STEPS must equal WIDTH");
  end

  alu_state_t       state;
  logic [3:0]       flags;
  logic [3:0]       flags_new;
  logic [WIDTH:0]   dr_x, sr_x, cin_x, ext;
  logic [WIDTH-1:0] res;
  logic             c_new, v_new, wr_res, wr_flags;

  assign dr_x  = {1'b0, alu_dr};
  assign sr_x  = {1'b0, alu_sr};
  assign cin_x = {{WIDTH{1'b0}}, flags[FLAG_C]};

  always_comb begin
    ext      = '0;
    res      = alu_result;
    c_new    = 1'b0;
    v_new    = 1'b0;
    wr_res   = 1'b1;
    wr_flags = 1'b1;
    case (alu_op)
      ALU_ADD: begin
        ext   = dr_x + sr_x;
        res   = ext[MSB:0];
        c_new = ext[WIDTH];
        v_new = ovf_add(alu_dr[MSB], alu_sr[MSB], res[MSB]);
      end
      ALU_SUB, ALU_CMP: begin
        ext    = dr_x - sr_x;
        res    = ext[MSB:0];
        c_new  = ext[WIDTH];
        v_new  = ovf_sub(alu_dr[MSB], alu_sr[MSB], res[MSB]);
        wr_res = (alu_op != ALU_CMP);
      end
      ALU_AND:  res = alu_dr & alu_sr;
      ALU_OR:   res = alu_dr | alu_sr;
      ALU_XOR:  res = alu_dr ^ alu_sr;
      ALU_NOT:  res = ~alu_dr;
      ALU_SHL: begin
        res   = {alu_dr[MSB-1:0], 1'b0};
        c_new = alu_dr[MSB];
      end
      ALU_SHR: begin
        res   = {1'b0, alu_dr[MSB:1]};
        c_new = alu_dr[0];
      end
      ALU_SAR: begin
        res   = {alu_dr[MSB], alu_dr[MSB:1]};
        c_new = alu_dr[0];
      end
      ALU_ADC: begin
        ext   = dr_x + sr_x + cin_x;
        res   = ext[MSB:0];
        c_new = ext[WIDTH];
        v_new = ovf_add(alu_dr[MSB], alu_sr[MSB], res[MSB]);
      end
      ALU_SBB: begin
        ext   = dr_x - sr_x - cin_x;
        res   = ext[MSB:0];
        c_new = ext[WIDTH];
        v_new = ovf_sub(alu_dr[MSB], alu_sr[MSB], res[MSB]);
      end
      ALU_INC: begin
        ext   = dr_x + ONE_X;
        res   = ext[MSB:0];
        c_new = ext[WIDTH];
        v_new = ovf_add(alu_dr[MSB], 1'b0, res[MSB]);
      end
      ALU_DEC: begin
        ext   = dr_x - ONE_X;
        res   = ext[MSB:0];
        c_new = ext[WIDTH];
        v_new = ovf_sub(alu_dr[MSB], 1'b0, res[MSB]);
      end
      ALU_PASS: res = alu_sr;
      default: begin
        wr_res   = 1'b0;
        wr_flags = 1'b0;
      end
    endcase
    flags_new = pack_flags(c_new, (res == '0), v_new, res[MSB]);
  end

`ifdef ALU_MUL_EN
  localparam int CNT_W = $clog2(MUL_STEPS);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(MUL_STEPS - 1);

  logic [CNT_W-1:0]   step_cnt;
  logic               mul_flag_we;
  logic               mul_load, mul_step;
  logic [2*WIDTH-1:0] prod_next;
  logic [3:0]         mul_flags;

  assign mul_load  = (state == ST_IDLE) && alu_start && (alu_op == ALU_MUL);
  assign mul_step  = (state == ST_MUL);
  assign mul_flags = pack_flags(|prod_next[2*WIDTH-1:WIDTH], (prod_next[MSB:0] == '0),
                                |prod_next[2*WIDTH-1:WIDTH], prod_next[MSB]);

  alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk          (clk),
    .rst          (rst),
    .load         (mul_load),
    .step         (mul_step),
    .mcand        (alu_dr),
    .mplier       (alu_sr),
    .product_next (prod_next)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      alu_result <= '0;
      flags      <= '0;
      alu_busy   <= 1'b0;
      alu_done   <= 1'b0;
`ifdef ALU_MUL_EN
      step_cnt    <= '0;
      mul_flag_we <= 1'b0;
`endif
    end else begin
      alu_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (alu_start) begin
`ifdef ALU_MUL_EN
            if (alu_op == ALU_MUL) begin
              state       <= ST_MUL;
              alu_busy    <= 1'b1;
              step_cnt    <= STEP_LAST;
              mul_flag_we <= flag_we;
            end else
`endif
            begin
              alu_done <= 1'b1;
              if (wr_res)              alu_result <= res;
              if (wr_flags && flag_we) flags      <= flags_new;
            end
          end
        end
`ifdef ALU_MUL_EN
        ST_MUL: begin
          // Down-counter: the edge that sees zero performs the final step.
          if (step_cnt == '0) begin
            state      <= ST_IDLE;
            alu_busy   <= 1'b0;
            alu_done   <= 1'b1;
            alu_result <= prod_next[MSB:0];
            if (mul_flag_we) flags <= mul_flags;
          end else begin
            step_cnt <= step_cnt - 1'b1;
          end
        end
`endif
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign flag_c = flags[FLAG_C];
  assign flag_z = flags[FLAG_Z];
  assign flag_v = flags[FLAG_V];
  assign flag_s = flags[FLAG_S];

endmodule

// File: tb/tb_alu_core.sv
// Self-checking bench for alu_core: directed cases plus random ops against an arithmetic model.
module tb_alu_core;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_start = 1'b0;
  logic [3:0]  alu_op = 4'h0;
  logic        flag_we = 1'b0;
  logic [15:0] alu_sr = 16'h0;
  logic [15:0] alu_dr = 16'h0;
  logic [15:0] alu_result;
  logic        alu_busy, alu_done, flag_c, flag_z, flag_v, flag_s;

  int n_cmp = 0;
  int n_err = 0;

  // Model state: flags ordered {C,Z,V,S}
  logic [15:0] m_res = 16'h0;
  logic [3:0]  m_flg = 4'h0;

  alu_core dut (
    .clk        (clk),
    .rst        (rst),
    .alu_start  (alu_start),
    .alu_op     (alu_op),
    .flag_we    (flag_we),
    .alu_sr     (alu_sr),
    .alu_dr     (alu_dr),
    .alu_result (alu_result),
    .alu_busy   (alu_busy),
    .alu_done   (alu_done),
    .flag_c     (flag_c),
    .flag_z     (flag_z),
    .flag_v     (flag_v),
    .flag_s     (flag_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic done_exp);
    check({tag, "_res"}, alu_result, m_res);
    check({tag, "_flags"}, 16'({flag_c, flag_z, flag_v, flag_s}), 16'(m_flg));
    check({tag, "_done"}, 16'(alu_done), 16'(done_exp));
    check({tag, "_busy"}, 16'(alu_busy), 16'h0);
  endtask

  // Behavioural model straight from the opcode rules using integer arithmetic.
  task automatic model(input logic [3:0] op, input logic [15:0] dr, input logic [15:0] sr,
                       input logic fwe);
    longint a, b, r, sa, sb, sv, cin;
    logic c, v, arith, keep, nop;
    logic [15:0] rr;
    a = longint'(dr); b = longint'(sr); r = 0; sv = 0;
    sa = longint'($signed(dr)); sb = longint'($signed(sr));
    cin = longint'(m_flg[3]);
    c = 1'b0; v = 1'b0; arith = 1'b0; keep = 1'b0; nop = 1'b0;
    case (op)
      4'h0: begin r = a + b; c = (r > 65535); sv = sa + sb; arith = 1'b1; end
      4'h1: begin r = a - b; c = (a < b); sv = sa - sb; arith = 1'b1; end
      4'h2: r = a & b;
      4'h3: r = a | b;
      4'h4: r = a ^ b;
      4'h5: r = ~a;
      4'h6: begin r = a << 1; c = a[15]; end
      4'h7: begin r = a >> 1; c = a[0]; end
      4'h8: begin r = sa >>> 1; c = a[0]; end
      4'h9: begin r = a + b + cin; c = (r > 65535); sv = sa + sb + cin; arith = 1'b1; end
      4'hA: begin r = a - b - cin; c = (a < b + cin); sv = sa - sb - cin; arith = 1'b1; end
      4'hB: begin r = a - b; c = (a < b); sv = sa - sb; arith = 1'b1; keep = 1'b1; end
      4'hC: begin r = a + 1; c = (r > 65535); sv = sa + 1; arith = 1'b1; end
      4'hD: begin r = a - 1; c = (a < 1); sv = sa - 1; arith = 1'b1; end
      4'hE: r = b;
      default: begin
`ifdef ALU_MUL_EN
        r = a * b;
        c = ((r >> 16) != 0);
        v = c;
`else
        nop = 1'b1;
`endif
      end
    endcase
    if (arith) v = (sv > 32767) || (sv < -32768);
    rr = r[15:0];
    if (!nop) begin
      if (!keep) m_res = rr;
      if (fwe) m_flg = {c, (rr == 16'h0), v, rr[15]};
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [15:0] dr, input logic [15:0] sr,
                        input logic fwe, input string tag);
    alu_op = op; alu_dr = dr; alu_sr = sr; flag_we = fwe; alu_start = 1'b1;
    model(op, dr, sr, fwe);
    @(posedge clk); #1;
    alu_start = 1'b0;
    check_state(tag, 1'b1);
  endtask

  task automatic idle_cycle(input string tag);
    @(posedge clk); #1;
    check_state(tag, 1'b0);
  endtask

`ifdef ALU_MUL_EN
  task automatic run_mul(input logic [15:0] dr, input logic [15:0] sr, input logic fwe,
                         input string tag);
    logic [15:0] old_res;
    old_res = m_res;
    alu_op = 4'hF; alu_dr = dr; alu_sr = sr; flag_we = fwe; alu_start = 1'b1;
    model(4'hF, dr, sr, fwe);
    @(posedge clk); #1;
    alu_start = 1'b0;
    check({tag, "_busy0"}, 16'(alu_busy), 16'h1);
    check({tag, "_done0"}, 16'(alu_done), 16'h0);
    for (int i = 1; i <= 15; i++) begin
      if (i == 4) begin
        alu_op = 4'h0; alu_dr = 16'h1111; alu_sr = 16'h2222; flag_we = 1'b1; alu_start = 1'b1;
      end
      @(posedge clk); #1;
      alu_start = 1'b0;
      check({tag, "_busy"}, 16'(alu_busy), 16'h1);
      check({tag, "_nodone"}, 16'(alu_done), 16'h0);
      check({tag, "_held"}, alu_result, old_res);
    end
    @(posedge clk); #1;
    check_state({tag, "_end"}, 1'b1);
    idle_cycle({tag, "_after"});
  endtask
`endif

  initial begin
    // Reset
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_state("reset", 1'b0);
    rst = 1'b0;

    // 1: ADD overflow into sign
    run_op(4'h0, 16'h7FFF, 16'h0001, 1'b1, "t1_add");
    check("t1_lit_res", alu_result, 16'h8000);
    check("t1_lit_flags", 16'({flag_c, flag_z, flag_v, flag_s}), 16'b0011);

    // 2: SUB borrow, then CMP equal holds result
    run_op(4'h1, 16'h0003, 16'h0005, 1'b1, "t2_sub");
    check("t2_lit_res", alu_result, 16'hFFFE);
    run_op(4'hB, 16'h0005, 16'h0005, 1'b1, "t2_cmp");
    check("t2_lit_cmp", 16'({alu_result, flag_z}), 16'({16'hFFFE, 1'b1}));

    // 3: flag_we=0 holds flags; SHR shifting out a one
    run_op(4'h0, 16'h0010, 16'h0020, 1'b0, "t3_add_nowe");
    run_op(4'h7, 16'h0001, 16'h0000, 1'b1, "t3_shr");
    check("t3_lit_cz", 16'({flag_c, flag_z}), 16'h3);
    idle_cycle("t3_idle");

    // Boundary ops: carry chains and INC/DEC wrap
    run_op(4'h0, 16'hFFFF, 16'h0001, 1'b1, "b_add_carry");
    run_op(4'h9, 16'h0000, 16'h0000, 1'b1, "b_adc_cin");
    run_op(4'h1, 16'h0000, 16'h0001, 1'b1, "b_sub_borrow");
    run_op(4'hA, 16'h0005, 16'h0004, 1'b1, "b_sbb_bin");
    run_op(4'hC, 16'h7FFF, 16'h0000, 1'b1, "b_inc_ovf");
    run_op(4'hD, 16'h8000, 16'h0000, 1'b1, "b_dec_ovf");
    run_op(4'h8, 16'h8001, 16'h0000, 1'b1, "b_sar");
    run_op(4'h6, 16'h8000, 16'h0000, 1'b1, "b_shl");

    // Reset wins over a simultaneous start
    rst = 1'b1;
    alu_op = 4'hE; alu_sr = 16'hABCD; alu_start = 1'b1; flag_we = 1'b1;
    @(posedge clk); #1;
    alu_start = 1'b0; rst = 1'b0;
    m_res = 16'h0; m_flg = 4'h0;
    check_state("rst_vs_start", 1'b0);

`ifdef ALU_MUL_EN
    // 4: multiply with a start ignored while busy
    run_mul(16'h0100, 16'h0100, 1'b1, "t4_mul");
    run_mul(16'h0123, 16'h0045, 1'b1, "t4_mul_small");
    run_mul(16'($urandom), 16'($urandom), 1'b1, "t4_mul_rand");

    // 5: reset during multiply cycle 8
    run_op(4'hE, 16'h0000, 16'h5A5A, 1'b1, "t5_pre");
    alu_op = 4'hF; alu_dr = 16'h1234; alu_sr = 16'h0003; alu_start = 1'b1;
    @(posedge clk); #1;
    alu_start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("t5_busy_mid", 16'(alu_busy), 16'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    m_res = 16'h0; m_flg = 4'h0;
    check_state("t5_rst", 1'b0);
    idle_cycle("t5_after");
`else
    // 6: opcode F is a single-cycle NOP
    run_op(4'h1, 16'h0003, 16'h0005, 1'b1, "t6_pre");
    run_op(4'hF, 16'h1234, 16'h5678, 1'b1, "t6_nop");
    check("t6_lit_res", alu_result, 16'hFFFE);
    idle_cycle("t6_idle");
`endif

    // Random back-to-back ops with occasional idle gaps
    for (int i = 0; i < 300; i++) begin
      logic [3:0] op;
`ifdef ALU_MUL_EN
      op = 4'($urandom_range(0, 14));
`else
      op = 4'($urandom_range(0, 15));
`endif
      run_op(op, 16'($urandom), 16'($urandom), 1'($urandom_range(0, 3) != 0), "rnd");
      if ($urandom_range(0, 4) == 0) idle_cycle("rnd_idle");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
